mcu_ld_st_seq: RTL and testbench

Memory-side sequencer of the M_CU that responds to the scheduler's load/store handshake. Accepts one load or store descriptor (base address, stride, data width, addressing mode), expands it into a per-element stream of memory requests, counts returning load data, and signals `mcu_ld_buffered_o` once the whole load is buffered. Sits between the scheduler's M_CU port and the data-memory request/response interface.

---
 rtl/typedef_pkg.sv | 37 +++
 rtl/mcu_addr_gen.sv | 81 ++++++++
 rtl/mcu_ld_st_seq.sv | 163 ++++++++++++++++
 tb/tb_mcu_ld_st_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/typedef_pkg.sv
// Shared types for the M_CU sequencer and scheduler:
// FSM states, RVV width encodings and addressing-mode (mop) codes.
package typedef_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LD_REQ,
    S_LD_DRAIN,
    S_ST_REQ
  } mcu_seq_state_t;

  localparam logic [2:0] W8  = 3'b000;
  localparam logic [2:0] W16 = 3'b101;
  localparam logic [2:0] W32 = 3'b110;

  // Same encoding as the mop field decoded by the scheduler
  typedef enum logic [1:0] {
    MOP_UNIT    = 2'b00,
    MOP_IDX_U   = 2'b01,
    MOP_STRIDED = 2'b10,
    MOP_IDX_O   = 2'b11
  } mop_t;

  function automatic logic [1:0] width2size(
    input logic [2:0] w
  );
    logic [1:0] s;
    case (w)
      W8:      s = 2'd0;
      W16:     s = 2'd1;
      W32:     s = 2'd2;
      default: s = 2'd2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mcu_addr_gen.sv
// Element address generator: latches the descriptor, maps width to
// size and advances the accumulator per accepted request. MCU_IDX_EN adds idx.
module mcu_addr_gen
  import typedef_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [AW-1:0] base_i,
  input  logic [31:0]   stride_i,
  input  logic [2:0]    width_i,
  input  logic          strided_i,
`ifdef MCU_IDX_EN
  input  logic          idx_i,
  input  logic [31:0]   idx_offset_i,
  output logic          is_idx_o,
`endif
  output logic [AW-1:0] addr_o,
  output logic [1:0]    size_o
);

  logic [AW-1:0] base_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [31:0]   stride_q;
  logic [1:0]    size_q;
  mop_t          mode_q;
  mop_t          mode_d;
  logic [AW-1:0] step;

  always_comb begin
`ifdef MCU_IDX_EN
    if (idx_i)          mode_d = MOP_IDX_U;
    else if (strided_i) mode_d = MOP_STRIDED;
    else                mode_d = MOP_UNIT;
`else
    if (strided_i) mode_d = MOP_STRIDED;
    else           mode_d = MOP_UNIT;
`endif
  end

  // Negative strides wrap modulo 2^AW
  always_comb begin
    if (mode_q == MOP_STRIDED)
      step = AW'($signed(stride_q));
    else
      step = AW'(1) << size_q;
    acc_d = acc_q + step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      acc_q    <= '0;
      stride_q <= '0;
      size_q   <= '0;
      mode_q   <= MOP_UNIT;
    end else if (load_i) begin
      base_q   <= base_i;
      acc_q    <= base_i;
      stride_q <= stride_i;
      size_q   <= width2size(width_i);
      mode_q   <= mode_d;
    end else if (adv_i) begin
      acc_q <= acc_d;
    end
  end

`ifdef MCU_IDX_EN
  assign is_idx_o = (mode_q == MOP_IDX_U);
  assign addr_o   = is_idx_o ?
                    base_q + AW'(idx_offset_i) : acc_q;
`else
  assign addr_o = acc_q;
`endif
  assign size_o = size_q;

endmodule

// File: rtl/mcu_ld_st_seq.sv
// M_CU memory-side load/store sequencer: expands one descriptor into
// per-element requests and pulses buffered when a load is complete.
// Optional indexed addressing: MCU_IDX_EN.
module mcu_ld_st_seq
  import typedef_pkg::*;
#(
  parameter int VL_W = 12,
  parameter int AW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [VL_W-1:0] vl_i,
  input  logic            mcu_ld_vld_i,
  output logic            mcu_ld_rdy_o,
  output logic            mcu_ld_buffered_o,
  input  logic            mcu_st_vld_i,
  output logic            mcu_st_rdy_o,
  input  logic [AW-1:0]   mcu_base_addr_i,
  input  logic [31:0]     mcu_stride_i,
  input  logic [2:0]      mcu_data_width_i,
  input  logic            mcu_unit_ld_st_i,
  input  logic            mcu_strided_ld_st_i,
  input  logic            mcu_idx_ld_st_i,
  output logic            mem_req_vld_o,
  input  logic            mem_req_rdy_i,
  output logic [AW-1:0]   mem_req_addr_o,
  output logic            mem_req_we_o,
  output logic [1:0]      mem_req_size_o,
  input  logic            mem_rsp_vld_i,
`ifdef MCU_IDX_EN
  input  logic            idx_vld_i,
  input  logic [31:0]     idx_offset_i,
  output logic            idx_rdy_o,
`endif
  input  logic            st_data_vld_i
);

  localparam int CW = VL_W + 1;

  mcu_seq_state_t state_q;
  logic [CW-1:0]  vl_q;
  logic [CW-1:0]  req_cnt_q;
  logic [CW-1:0]  rsp_cnt_q;
  logic           buf_q;
  logic           we_q;

  logic          idle;
  logic          ld_acc;
  logic          st_acc;
  logic          load;
  logic          base_vld;
  logic          req_vld;
  logic          req_fire;
  logic          last_req;
  logic          rsp_take;
  logic [CW-1:0] vl_ext;

  assign idle   = (state_q == S_IDLE);
  assign ld_acc = idle & mcu_ld_vld_i;
  assign st_acc = idle & ~mcu_ld_vld_i & mcu_st_vld_i;
  assign load   = ld_acc | st_acc;
  assign vl_ext = CW'(vl_i);

  assign base_vld = (state_q == S_LD_REQ) |
                    ((state_q == S_ST_REQ) & st_data_vld_i);

`ifdef MCU_IDX_EN
  logic is_idx;
  assign req_vld   = base_vld & (~is_idx | idx_vld_i);
  assign idx_rdy_o = req_fire & is_idx;
  logic unused_mode;
  assign unused_mode = mcu_unit_ld_st_i;
`else
  assign req_vld = base_vld;
  logic unused_mode;
  assign unused_mode = ^{mcu_unit_ld_st_i, mcu_idx_ld_st_i};
`endif

  assign req_fire = req_vld & mem_req_rdy_i;
  assign last_req = req_fire &
                    ((req_cnt_q + CW'(1)) == vl_q);
  // Responses beyond vl or outside a load are dropped
  assign rsp_take = mem_rsp_vld_i &
                    ((state_q == S_LD_REQ) |
                     (state_q == S_LD_DRAIN)) &
                    (rsp_cnt_q != vl_q);

  mcu_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .adv_i       (req_fire),
    .base_i      (mcu_base_addr_i),
    .stride_i    (mcu_stride_i),
    .width_i     (mcu_data_width_i),
    .strided_i   (mcu_strided_ld_st_i),
`ifdef MCU_IDX_EN
    .idx_i       (mcu_idx_ld_st_i),
    .idx_offset_i(idx_offset_i),
    .is_idx_o    (is_idx),
`endif
    .addr_o      (mem_req_addr_o),
    .size_o      (mem_req_size_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vl_q      <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      buf_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      buf_q <= 1'b0;
      if (req_fire) req_cnt_q <= req_cnt_q + CW'(1);
      if (rsp_take) rsp_cnt_q <= rsp_cnt_q + CW'(1);
      case (state_q)
        S_IDLE: begin
          if (ld_acc) begin
            state_q   <= (vl_i == '0) ? S_LD_DRAIN
                                      : S_LD_REQ;
            vl_q      <= vl_ext;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            we_q      <= 1'b0;
          end else if (st_acc && vl_i != '0) begin
            state_q   <= S_ST_REQ;
            vl_q      <= vl_ext;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            we_q      <= 1'b1;
          end
        end
        S_LD_REQ: begin
          if (last_req) state_q <= S_LD_DRAIN;
        end
        S_LD_DRAIN: begin
          if (rsp_cnt_q == vl_q) begin
            buf_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_ST_REQ: begin
          if (last_req) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mcu_ld_rdy_o      = idle;
  assign mcu_st_rdy_o      = idle;
  assign mcu_ld_buffered_o = buf_q;
  assign mem_req_vld_o     = req_vld;
  assign mem_req_we_o      = we_q;

endmodule

// File: tb/tb_mcu_ld_st_seq.sv
// Directed bench for mcu_ld_st_seq with a small latency-configurable
// memory model; build with MCU_IDX_EN for the indexed case.
module tb_mcu_ld_st_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vl_i;
  logic        mcu_ld_vld_i;
  logic        mcu_ld_rdy_o;
  logic        mcu_ld_buffered_o;
  logic        mcu_st_vld_i;
  logic        mcu_st_rdy_o;
  logic [31:0] mcu_base_addr_i;
  logic [31:0] mcu_stride_i;
  logic [2:0]  mcu_data_width_i;
  logic        mcu_unit_ld_st_i;
  logic        mcu_strided_ld_st_i;
  logic        mcu_idx_ld_st_i;
  logic        mem_req_vld_o;
  logic        mem_req_rdy_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_we_o;
  logic [1:0]  mem_req_size_o;
  logic        mem_rsp_vld_i;
  logic        st_data_vld_i;
`ifdef MCU_IDX_EN
  logic        idx_vld_i;
  logic [31:0] idx_offset_i;
  logic        idx_rdy_o;
`endif

  mcu_ld_st_seq dut (
    .clk                (clk),
    .rst                (rst),
    .vl_i               (vl_i),
    .mcu_ld_vld_i       (mcu_ld_vld_i),
    .mcu_ld_rdy_o       (mcu_ld_rdy_o),
    .mcu_ld_buffered_o  (mcu_ld_buffered_o),
    .mcu_st_vld_i       (mcu_st_vld_i),
    .mcu_st_rdy_o       (mcu_st_rdy_o),
    .mcu_base_addr_i    (mcu_base_addr_i),
    .mcu_stride_i       (mcu_stride_i),
    .mcu_data_width_i   (mcu_data_width_i),
    .mcu_unit_ld_st_i   (mcu_unit_ld_st_i),
    .mcu_strided_ld_st_i(mcu_strided_ld_st_i),
    .mcu_idx_ld_st_i    (mcu_idx_ld_st_i),
    .mem_req_vld_o      (mem_req_vld_o),
    .mem_req_rdy_i      (mem_req_rdy_i),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_req_we_o       (mem_req_we_o),
    .mem_req_size_o     (mem_req_size_o),
    .mem_rsp_vld_i      (mem_rsp_vld_i),
`ifdef MCU_IDX_EN
    .idx_vld_i          (idx_vld_i),
    .idx_offset_i       (idx_offset_i),
    .idx_rdy_o          (idx_rdy_o),
`endif
    .st_data_vld_i      (st_data_vld_i)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int buf_cnt = 0;
  int viol = 0;
  int lat = 1;
  logic [3:0]  sr = '0;
  logic [32:0] reqs[$];
  logic [32:0] exp_q[$];

  // Memory model: load responses delayed by lat cycles (0 = same cycle)
  always @(posedge clk)
    sr <= {sr[2:0],
           mem_req_vld_o & mem_req_rdy_i & ~mem_req_we_o};

  always_comb begin
    mem_rsp_vld_i = 1'b0;
    if (lat == 0)
      mem_rsp_vld_i = mem_req_vld_o & mem_req_rdy_i &
                      ~mem_req_we_o;
    else
      mem_rsp_vld_i = sr[lat-1];
  end

  always @(negedge clk) begin
    if (!rst && mem_req_vld_o && mem_req_rdy_i)
      reqs.push_back({mem_req_we_o, mem_req_addr_o});
    if (mem_req_vld_o && mem_req_we_o && !st_data_vld_i)
      viol++;
    if (mcu_ld_buffered_o)
      buf_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic desc(input logic ld, input logic st,
                      input logic [31:0] base,
                      input logic [31:0] stride,
                      input logic [2:0] w,
                      input logic u, input logic s,
                      input logic x, input int vl);
    mcu_ld_vld_i        = ld;
    mcu_st_vld_i        = st;
    mcu_base_addr_i     = base;
    mcu_stride_i        = stride;
    mcu_data_width_i    = w;
    mcu_unit_ld_st_i    = u;
    mcu_strided_ld_st_i = s;
    mcu_idx_ld_st_i     = x;
    vl_i                = 12'(vl);
    tick();
    mcu_ld_vld_i = 1'b0;
    mcu_st_vld_i = 1'b0;
  endtask

  task automatic wait_buf(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mcu_ld_buffered_o && n < max);
    if (!mcu_ld_buffered_o) n = -1;
  endtask

  task automatic expect_seq(input logic we,
                            input logic [31:0] a0,
                            input logic [31:0] step,
                            input int n);
    logic [31:0] a;
    a = a0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({we, a});
      a = a + step;
    end
  endtask

  task automatic check_reqs(input string tag);
    chk({tag, "_count"}, 64'(reqs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < reqs.size(); i++)
      chk($sformatf("%s_req%0d", tag, i), 64'(reqs[i]),
          64'(exp_q[i]));
  endtask

  task automatic clr();
    reqs.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int b0;
    int v0;
    int k;
    int pc;
    int sc;
    logic acc;
    rst = 1'b1;
    vl_i = '0;
    mcu_ld_vld_i = 0;
    mcu_st_vld_i = 0;
    mcu_base_addr_i = '0;
    mcu_stride_i = '0;
    mcu_data_width_i = '0;
    mcu_unit_ld_st_i = 0;
    mcu_strided_ld_st_i = 0;
    mcu_idx_ld_st_i = 0;
    mem_req_rdy_i = 0;
    st_data_vld_i = 0;
`ifdef MCU_IDX_EN
    idx_vld_i = 0;
    idx_offset_i = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ld_rdy", 64'(mcu_ld_rdy_o), 64'd1);
    chk("rst_st_rdy", 64'(mcu_st_rdy_o), 64'd1);
    chk("rst_buf", 64'(mcu_ld_buffered_o), 64'd0);
    chk("rst_vld", 64'(mem_req_vld_o), 64'd0);
    chk("rst_we", 64'(mem_req_we_o), 64'd0);
    chk("rst_addr", 64'(mem_req_addr_o), 64'd0);
    chk("rst_size", 64'(mem_req_size_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Unit load, 1-cycle memory
    mem_req_rdy_i = 1;
    lat = 1;
    clr();
    b0 = buf_cnt;
    desc(1, 0, 32'h1000, 0, 3'b110, 1, 0, 0, 4);
    wait_buf(20, n);
    chk("unit_pulse_cyc", 64'(n), 64'd7);
    chk("unit_rdy_back", 64'(mcu_ld_rdy_o), 64'd1);
    repeat (5) tick();
    chk("unit_pulses", 64'(buf_cnt - b0), 64'd1);
    expect_seq(0, 32'h1000, 4, 4);
    check_reqs("unit");

    // Zero-latency memory: N+2 cycles to pulse
    lat = 0;
    clr();
    desc(1, 0, 32'h1100, 0, 3'b000, 1, 0, 0, 2);
    wait_buf(20, n);
    chk("zlat_pulse_cyc", 64'(n), 64'd4);
    tick();
    expect_seq(0, 32'h1100, 1, 2);
    check_reqs("zlat");

    // vl = 0 load
    lat = 1;
    clr();
    desc(1, 0, 32'h1200, 0, 3'b110, 1, 0, 0, 0);
    wait_buf(20, n);
    chk("vl0_pulse_cyc", 64'(n), 64'd2);
    repeat (3) tick();
    check_reqs("vl0");
    chk("vl0_idle", 64'(mcu_ld_rdy_o), 64'd1);

    // vl = 0 store issues nothing
    clr();
    b0 = buf_cnt;
    st_data_vld_i = 1;
    desc(0, 1, 32'h1300, 0, 3'b110, 1, 0, 0, 0);
    @(negedge clk);
    chk("st_vl0_rdy", 64'(mcu_st_rdy_o), 64'd1);
    tick();
    st_data_vld_i = 0;
    check_reqs("st_vl0");

    // Strided store, stride -8, data valid toggling
    clr();
    v0 = viol;
    desc(0, 1, 32'h2000, 32'hFFFF_FFF8, 3'b000,
         0, 1, 0, 3);
    k = 1;
    while (k < 20) begin
      st_data_vld_i = k[0];
      @(negedge clk);
      if (mcu_st_rdy_o) break;
      tick();
      k++;
    end
    st_data_vld_i = 0;
    chk("st_rdy_cyc", 64'(k), 64'd6);
    chk("st_ld_rdy", 64'(mcu_ld_rdy_o), 64'd1);
    tick();
    chk("st_viol", 64'(viol - v0), 64'd0);
    expect_seq(1, 32'h2000, 32'hFFFF_FFF8, 3);
    check_reqs("st");

    // Strided load wrapping below zero
    clr();
    desc(1, 0, 32'h4, 32'hFFFF_FFF8, 3'b110, 0, 1, 0, 2);
    wait_buf(20, n);
    chk("wrap_pulse_cyc", 64'(n), 64'd5);
    tick();
    expect_seq(0, 32'h4, 32'hFFFF_FFF8, 2);
    check_reqs("wrap");

    // Backpressure mid-load
    clr();
    desc(1, 0, 32'h3000, 0, 3'b101, 1, 0, 0, 5);
    tick();
    tick();
    mem_req_rdy_i = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("bp_vld%0d", j),
          64'(mem_req_vld_o), 64'd1);
      chk($sformatf("bp_addr%0d", j),
          64'(mem_req_addr_o), 64'h3004);
      chk($sformatf("bp_size%0d", j),
          64'(mem_req_size_o), 64'd1);
      tick();
    end
    mem_req_rdy_i = 1;
    wait_buf(30, n);
    chk("bp_pulse_cyc", 64'(n), 64'd6);
    tick();
    expect_seq(0, 32'h3000, 2, 5);
    check_reqs("bp");

    // Simultaneous load and store: load first
    clr();
    desc(1, 1, 32'h4000, 0, 3'b110, 1, 0, 0, 2);
    mcu_st_vld_i = 1;
    st_data_vld_i = 1;
    pc = -1;
    sc = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (mcu_ld_buffered_o) pc = j;
      if (mem_req_vld_o && mem_req_we_o && sc < 0) sc = j;
      acc = mcu_st_rdy_o & mcu_st_vld_i;
      tick();
      if (acc) mcu_st_vld_i = 0;
    end
    mcu_st_vld_i = 0;
    st_data_vld_i = 0;
    chk("both_pulse_cyc", 64'(pc), 64'd5);
    chk("both_st_cyc", 64'(sc), 64'd6);
    expect_seq(0, 32'h4000, 4, 2);
    expect_seq(1, 32'h4000, 4, 2);
    check_reqs("both");

    // Reset in LD_DRAIN with two responses outstanding
    lat = 3;
    clr();
    b0 = buf_cnt;
    desc(1, 0, 32'h5000, 0, 3'b110, 1, 0, 0, 4);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("arst_rdy", 64'(mcu_ld_rdy_o), 64'd1);
    chk("arst_vld", 64'(mem_req_vld_o), 64'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("arst_no_pulse", 64'(buf_cnt - b0), 64'd0);
    lat = 1;
    clr();
    desc(1, 0, 32'h5100, 0, 3'b110, 1, 0, 0, 3);
    wait_buf(20, n);
    chk("arst_next_cyc", 64'(n), 64'd6);
    tick();
    expect_seq(0, 32'h5100, 4, 3);
    check_reqs("arst_next");

`ifdef MCU_IDX_EN
    // Indexed load: address = base + offset
    clr();
    idx_vld_i = 1;
    desc(1, 0, 32'h100, 0, 3'b110, 0, 0, 1, 2);
    idx_offset_i = 32'h10;
    @(negedge clk);
    chk("idx_rdy0", 64'(idx_rdy_o), 64'd1);
    tick();
    idx_offset_i = 32'h4;
    @(negedge clk);
    chk("idx_rdy1", 64'(idx_rdy_o), 64'd1);
    tick();
    @(negedge clk);
    chk("idx_rdy2", 64'(idx_rdy_o), 64'd0);
    idx_vld_i = 0;
    repeat (5) tick();
    exp_q.push_back({1'b0, 32'h110});
    exp_q.push_back({1'b0, 32'h104});
    check_reqs("idx");
`else
    // Idx flag ignored: treated as unit stride
    clr();
    desc(1, 0, 32'h100, 0, 3'b110, 0, 0, 1, 2);
    wait_buf(20, n);
    chk("noidx_pulse_cyc", 64'(n), 64'd5);
    tick();
    expect_seq(0, 32'h100, 4, 2);
    check_reqs("noidx");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
